// File: rtl/mux_sel_sync_apply_pkg.sv
// Shared definitions for the frame-synchronous mux select applier:
// FSM state codes, register-word field positions and field extraction.
package mux_sel_sync_apply_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_SYNC = 2'd1;
  localparam logic [1:0] ST_APPLY     = 2'd2;

  localparam int FORCE_BIT = 31;

  // Select field sits in the low bits; the caller truncates to its own width.
  function automatic logic [31:0] sel_field(input logic [31:0] w, input int unsigned sel_w);
    return w & ((32'h1 << sel_w) - 32'h1);
  endfunction

  function automatic logic force_field(input logic [31:0] w);
    return w[FORCE_BIT];
  endfunction

endpackage

// File: rtl/mux_sel_sync_apply_if.sv
// Bus between the software register / frame-sync source and the select applier.
interface mux_sel_sync_apply_if #(
  parameter int SEL_W = 3,
  parameter int CNT_W = 16
);
  // No valid/ready: data_in is a quasi-static level sampled every cycle,
  // sync_in is a one-cycle frame pulse, and every output is a registered level/strobe.
  logic [31:0]      data_in;
  logic             sync_in;
  logic [SEL_W-1:0] sel_out;
  logic             sync_out;
  logic             applied;
  logic             pending;
  logic [CNT_W-1:0] update_cnt;
  logic [1:0]       state;

  modport master (
    output data_in, sync_in,
    input  sel_out, sync_out, applied, pending, update_cnt, state
  );

  modport slave (
    input  data_in, sync_in,
    output sel_out, sync_out, applied, pending, update_cnt, state
  );
endinterface

// File: rtl/mux_sel_stab_filter.sv
// Registers the select/force fields of the register word and flags when the
// sample has been unchanged for STABLE_CYCLES consecutive cycles.
module mux_sel_stab_filter
  import mux_sel_sync_apply_pkg::*;
#(
  parameter int SEL_W         = 3,
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      data_in,
  output logic [SEL_W-1:0] samp_sel,
  output logic             samp_force,
  output logic             stable
);

  localparam logic [7:0] STAB_MAX = 8'(STABLE_CYCLES);

  logic [SEL_W-1:0] in_sel;
  logic             in_force;
  logic [7:0]       stab_cnt;

  assign in_sel   = SEL_W'(sel_field(data_in, SEL_W));
  assign in_force = force_field(data_in);

  // The counter describes the sample it is loaded alongside, so compare the
  // incoming fields against the sample being replaced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp_sel   <= '0;
      samp_force <= 1'b0;
      stab_cnt   <= 8'd0;
    end else begin
      samp_sel   <= in_sel;
      samp_force <= in_force;
      if (in_sel != samp_sel || in_force != samp_force)
        stab_cnt <= 8'd0;
      else if (stab_cnt != STAB_MAX)
        stab_cnt <= stab_cnt + 8'd1;
    end
  end

  assign stable = (stab_cnt == STAB_MAX);

endmodule

// File: rtl/mux_sel_sync_apply.sv
// Applies a filtered PFB mux select only on a frame sync boundary (or at once
// when the force bit is set), with a re-aligned sync, status and update count.
module mux_sel_sync_apply
  import mux_sel_sync_apply_pkg::*;
#(
  parameter int               SEL_W         = 3,
  parameter int               STABLE_CYCLES = 4,
  parameter logic [SEL_W-1:0] DEFAULT_SEL   = '0,
  parameter int               CNT_W         = 16
) (
  input logic                 user_clk,
  input logic                 user_rst,
  mux_sel_sync_apply_if.slave bus
);

  logic [SEL_W-1:0] samp_sel;
  logic             samp_force;
  logic             stable;

  mux_sel_stab_filter #(
    .SEL_W         (SEL_W),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_filter (
    .clk        (user_clk),
    .rst        (user_rst),
    .data_in    (bus.data_in),
    .samp_sel   (samp_sel),
    .samp_force (samp_force),
    .stable     (stable)
  );

  logic [1:0]       state, state_nx;
  logic [SEL_W-1:0] target, target_nx;
  logic [SEL_W-1:0] sel_q;
  logic [CNT_W-1:0] cnt_q;
  logic             applied_q, pending_q, sync_q;

  // A waiting target was latched with force=0, so any force bit or select
  // difference means the register moved away from it.
  always_comb begin
    state_nx  = state;
    target_nx = target;
    case (state)
      ST_IDLE: begin
        if (stable && samp_sel != sel_q) begin
          target_nx = samp_sel;
          state_nx  = samp_force ? ST_APPLY : ST_WAIT_SYNC;
        end
      end
      ST_WAIT_SYNC: begin
        if (samp_force || samp_sel != target)
          state_nx = ST_IDLE;
        else if (bus.sync_in)
          state_nx = ST_APPLY;
      end
      ST_APPLY: state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Outputs are loaded on the edge that enters a state, so applied/sel_out
  // line up with the registered sync.
  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      state     <= ST_IDLE;
      target    <= DEFAULT_SEL;
      sel_q     <= DEFAULT_SEL;
      cnt_q     <= '0;
      applied_q <= 1'b0;
      pending_q <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      state     <= state_nx;
      target    <= target_nx;
      sync_q    <= bus.sync_in;
      applied_q <= (state_nx == ST_APPLY);
      pending_q <= (state_nx == ST_WAIT_SYNC);
      if (state_nx == ST_APPLY) begin
        sel_q <= target_nx;
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.sel_out    = sel_q;
  assign bus.sync_out   = sync_q;
  assign bus.applied    = applied_q;
  assign bus.pending    = pending_q;
  assign bus.update_cnt = cnt_q;
  assign bus.state      = state;

endmodule
